// File: rtl/sync_porch_if.sv
// Video stream bundle for sync_porch: upstream active flags and pixels in,
// porch-corrected syncs, delayed pixels and reconstructed position out.
interface sync_porch_if #(
    parameter int VIDEO_WIDTH = 3
);
    logic                   i_HSync;
    logic                   i_VSync;
    logic [VIDEO_WIDTH-1:0] i_Red;
    logic [VIDEO_WIDTH-1:0] i_Grn;
    logic [VIDEO_WIDTH-1:0] i_Blu;
    logic                   o_HSync;
    logic                   o_VSync;
    logic [VIDEO_WIDTH-1:0] o_Red;
    logic [VIDEO_WIDTH-1:0] o_Grn;
    logic [VIDEO_WIDTH-1:0] o_Blu;
    logic [9:0]             o_Col;
    logic [9:0]             o_Row;
    logic                   o_Active;
    logic                   o_Locked;

    modport master (
        output i_HSync, i_VSync, i_Red, i_Grn, i_Blu,
        input  o_HSync, o_VSync, o_Red, o_Grn, o_Blu, o_Col, o_Row, o_Active, o_Locked
    );

    modport slave (
        input  i_HSync, i_VSync, i_Red, i_Grn, i_Blu,
        output o_HSync, o_VSync, o_Red, o_Grn, o_Blu, o_Col, o_Row, o_Active, o_Locked
    );
endinterface

// File: rtl/sync_porch.sv
// Rebuilds column/row from upstream active-area flags, aligns on the V flag
// rising edge and emits porch-corrected active-low syncs with 2-cycle latency.
module sync_porch #(
    parameter int TOTAL_COLS    = 800,
    parameter int TOTAL_ROWS    = 525,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int H_FRONT_PORCH = 18,
    parameter int H_BACK_PORCH  = 50,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_BACK_PORCH  = 33,
    parameter int VIDEO_WIDTH   = 3
) (
    input logic         CLK,
    input logic         RST,
    sync_porch_if.slave vif
);
    localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
    localparam logic [9:0] HS_FIRST = 10'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [9:0] HS_LAST  = 10'(TOTAL_COLS - H_BACK_PORCH - 1);
    localparam logic [9:0] VS_FIRST = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [9:0] VS_LAST  = 10'(TOTAL_ROWS - V_BACK_PORCH - 1);

    // stage 1
    logic                   vld1_q, vld1_d;
    logic                   hs1_q, hs1_d;
    logic                   vs1_q, vs1_d;
    logic [VIDEO_WIDTH-1:0] red1_q, red1_d, grn1_q, grn1_d, blu1_q, blu1_d;
    logic [9:0]             col_q, col_d, row_q, row_d;
    logic                   locked_q, locked_d;
    logic                   frame_start;

    // stage 2
    logic                   hsync_q, hsync_d, vsync_q, vsync_d;
    logic [VIDEO_WIDTH-1:0] red2_q, red2_d, grn2_q, grn2_d, blu2_q, blu2_d;
    logic [9:0]             col2_q, col2_d, row2_q, row2_d;
    logic                   active_q, active_d;
    logic                   locked2_q, locked2_d;

    // The column counter is the authority for horizontal position; the
    // registered H flag is carried only to keep the stage-1 capture complete.
    logic unused_hs;
    assign unused_hs = hs1_q;

    // vld1_q blocks a false edge right after reset, when vs1_q reads 0 but no
    // real low V flag has been sampled yet (e.g. reset released mid-frame).
    always_comb begin
        frame_start = vld1_q & vif.i_VSync & ~vs1_q;
        vld1_d      = 1'b1;
        hs1_d       = vif.i_HSync;
        vs1_d       = vif.i_VSync;
        red1_d      = vif.i_Red;
        grn1_d      = vif.i_Grn;
        blu1_d      = vif.i_Blu;
        col_d       = col_q + 10'd1;
        row_d       = row_q;
        locked_d    = locked_q;
        if (frame_start) begin
            col_d    = '0;
            row_d    = '0;
            locked_d = 1'b1;
        end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
        end
    end

    always_comb begin
        active_d  = locked_q && (col_q < ACT_COLS) && (row_q < ACT_ROWS);
        hsync_d   = ~(locked_q && (col_q >= HS_FIRST) && (col_q <= HS_LAST));
        vsync_d   = ~(locked_q && (row_q >= VS_FIRST) && (row_q <= VS_LAST));
        red2_d    = active_d ? red1_q : '0;
        grn2_d    = active_d ? grn1_q : '0;
        blu2_d    = active_d ? blu1_q : '0;
        col2_d    = col_q;
        row2_d    = row_q;
        locked2_d = locked_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld1_q    <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            red1_q    <= '0;
            grn1_q    <= '0;
            blu1_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            locked_q  <= 1'b0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            red2_q    <= '0;
            grn2_q    <= '0;
            blu2_q    <= '0;
            col2_q    <= '0;
            row2_q    <= '0;
            active_q  <= 1'b0;
            locked2_q <= 1'b0;
        end else begin
            vld1_q    <= vld1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            red1_q    <= red1_d;
            grn1_q    <= grn1_d;
            blu1_q    <= blu1_d;
            col_q     <= col_d;
            row_q     <= row_d;
            locked_q  <= locked_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            red2_q    <= red2_d;
            grn2_q    <= grn2_d;
            blu2_q    <= blu2_d;
            col2_q    <= col2_d;
            row2_q    <= row2_d;
            active_q  <= active_d;
            locked2_q <= locked2_d;
        end
    end

    assign vif.o_HSync  = hsync_q;
    assign vif.o_VSync  = vsync_q;
    assign vif.o_Red    = red2_q;
    assign vif.o_Grn    = grn2_q;
    assign vif.o_Blu    = blu2_q;
    assign vif.o_Col    = col2_q;
    assign vif.o_Row    = row2_q;
    assign vif.o_Active = active_q;
    assign vif.o_Locked = locked2_q;
endmodule

// File: tb/tb_sync_porch.sv
// Scoreboard bench for sync_porch on a scaled 80x30 raster (64x20 active),
// plus per-scenario line/frame counts, mid-frame start and mid-frame reset.
module tb_sync_porch;
    localparam int TC = 80, TR = 30, AC = 64, AR = 20;
    localparam int HFP = 4, HBP = 6, VFP = 3, VBP = 4, VW = 3;

    typedef struct packed {
        logic          lk, hs, vs, act;
        logic [VW-1:0] r, g, b;
        logic [9:0]    col, row;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    sync_porch_if #(.VIDEO_WIDTH(VW)) vif ();

    sync_porch #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .H_FRONT_PORCH(HFP), .H_BACK_PORCH(HBP),
        .V_FRONT_PORCH(VFP), .V_BACK_PORCH(VBP), .VIDEO_WIDTH(VW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .vif(vif)
    );

    exp_t sb_q[$];
    int   chk_cnt = 0, pass_cnt = 0;
    int   ucol = 0, urow = 0, last_col = 0, last_row = 0, rgb_mode = 0;
    logic prev_vs = 1'b0;
    bit   prev_valid = 1'b0, model_locked = 1'b0;

    // Drive one upstream pixel half a cycle before its capturing edge.
    task automatic step(input bit push);
        exp_t e;
        logic [VW-1:0] r, g, b;
        logic vs;
        @(negedge CLK);
        #1;
        if (rgb_mode == 1) begin
            r = 3'b101; g = 3'b101; b = 3'b101;
        end else begin
            r = VW'($urandom); g = VW'($urandom); b = VW'($urandom);
        end
        vs = (urow < AR);
        vif.i_HSync = (ucol < AC);
        vif.i_VSync = vs;
        vif.i_Red = r; vif.i_Grn = g; vif.i_Blu = b;
        if (push) begin
            if (prev_valid && vs && !prev_vs) model_locked = 1'b1;
            e.lk  = model_locked;
            e.act = model_locked && ucol < AC && urow < AR;
            e.hs  = !(model_locked && ucol >= AC + HFP && ucol <= TC - HBP - 1);
            e.vs  = !(model_locked && urow >= AR + VFP && urow <= TR - VBP - 1);
            e.r   = e.act ? r : '0;
            e.g   = e.act ? g : '0;
            e.b   = e.act ? b : '0;
            e.col = 10'(ucol);
            e.row = 10'(urow);
            sb_q.push_back(e);
            prev_valid = 1'b1;
        end else begin
            prev_valid = 1'b0;
        end
        prev_vs  = vs;
        last_col = ucol;
        last_row = urow;
        ucol++;
        if (ucol == TC) begin
            ucol = 0;
            urow = (urow + 1) % TR;
        end
    endtask

    always @(negedge CLK) begin : sb_blk
        exp_t e, a;
        if (!RST && sb_q.size() >= 2) begin
            e = sb_q.pop_front();
            a = {vif.o_Locked, vif.o_HSync, vif.o_VSync, vif.o_Active,
                 vif.o_Red, vif.o_Grn, vif.o_Blu, vif.o_Col, vif.o_Row};
            if (!e.lk) begin
                e.col = '0; e.row = '0; a.col = '0; a.row = '0;
            end
            chk_cnt++;
            if (a !== e)
                $display("FAIL sb_pixel t=%0t got %h expected %h", $time, a, e);
            else
                pass_cnt++;
        end
    end

    // Release reset with the last undriven-to-scoreboard pixel already on the inputs.
    task automatic release_reset();
        #1 RST = 1'b0;
        prev_valid = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        vif.i_HSync = 1'b0; vif.i_VSync = 1'b0;
        vif.i_Red = '0; vif.i_Grn = '0; vif.i_Blu = '0;
        repeat (3) @(negedge CLK);
        chk_cnt++;
        if (vif.o_Locked !== 1'b0) $display("FAIL reset_locked got %b expected 0", vif.o_Locked);
        else pass_cnt++;
        chk_cnt++;
        if ({vif.o_HSync, vif.o_VSync} !== 2'b11)
            $display("FAIL reset_syncs got %b%b expected 11", vif.o_HSync, vif.o_VSync);
        else pass_cnt++;
        chk_cnt++;
        if ({vif.o_Active, vif.o_Red, vif.o_Grn, vif.o_Blu, vif.o_Col, vif.o_Row} !== '0)
            $display("FAIL reset_data got act=%b rgb=%h%h%h col=%0d row=%0d expected zeros",
                     vif.o_Active, vif.o_Red, vif.o_Grn, vif.o_Blu, vif.o_Col, vif.o_Row);
        else pass_cnt++;
    endtask

    // From reset release, wait for the frame start while demanding idle outputs.
    task automatic relock(input string tag);
        int n = 0, bad = 0;
        do begin
            step(1);
            n++;
            if (vif.o_Locked !== 1'b0 || vif.o_HSync !== 1'b1 || vif.o_VSync !== 1'b1 ||
                vif.o_Active !== 1'b0 || {vif.o_Red, vif.o_Grn, vif.o_Blu} !== '0)
                bad++;
        end while (!(last_col == 0 && last_row == 0) && n < TC * TR + 10);
        chk_cnt++;
        if (!(last_col == 0 && last_row == 0))
            $display("FAIL %s_timeout no frame start within %0d cycles", tag, n);
        else pass_cnt++;
        chk_cnt++;
        if (bad != 0) $display("FAIL %s_idle got %0d non-idle samples expected 0", tag, bad);
        else pass_cnt++;
        step(1);
        step(1);
        chk_cnt++;
        if ({vif.o_Locked, vif.o_Col, vif.o_Row} !== {1'b1, 10'd0, 10'd0})
            $display("FAIL %s_align got lk=%b col=%0d row=%0d expected lk=1 col=0 row=0",
                     tag, vif.o_Locked, vif.o_Col, vif.o_Row);
        else pass_cnt++;
    endtask

    task automatic test_mid_start();
        ucol = 0; urow = 8; model_locked = 1'b0;
        repeat (3) step(0);
        release_reset();
        relock("midstart");
    endtask

    task automatic test_line(input string tag);
        int hcnt = 0, acnt = 0, hfirst = -1, hlast = -1;
        for (int i = 0; i < TC; i++) begin
            if (vif.o_HSync === 1'b0) begin
                hcnt++;
                if (hfirst < 0) hfirst = int'(vif.o_Col);
                hlast = int'(vif.o_Col);
            end
            if (vif.o_Active === 1'b1) acnt++;
            step(1);
        end
        chk_cnt++;
        if (hcnt != 6) $display("FAIL %s_hs_count got %0d expected 6", tag, hcnt);
        else pass_cnt++;
        chk_cnt++;
        if (hfirst != 68 || hlast != 73)
            $display("FAIL %s_hs_cols got %0d..%0d expected 68..73", tag, hfirst, hlast);
        else pass_cnt++;
        chk_cnt++;
        if (acnt != 64) $display("FAIL %s_active_count got %0d expected 64", tag, acnt);
        else pass_cnt++;
    endtask

    task automatic test_frame();
        int n = 0, vcnt = 0, vfirst = -1, vlast = -1, good = 0, bad = 0;
        rgb_mode = 1;
        step(1);
        while (!(vif.o_Col == 10'd0 && vif.o_Row == 10'd0) && n < TC * TR + 10) begin
            step(1);
            n++;
        end
        chk_cnt++;
        if (!(vif.o_Col == 10'd0 && vif.o_Row == 10'd0))
            $display("FAIL frame_timeout no frame origin within %0d cycles", n);
        else pass_cnt++;
        for (int i = 0; i < TC * TR; i++) begin
            if (vif.o_VSync === 1'b0) begin
                vcnt++;
                if (vfirst < 0) vfirst = int'(vif.o_Row);
                vlast = int'(vif.o_Row);
            end
            if (vif.o_Active === 1'b1) begin
                if ({vif.o_Red, vif.o_Grn, vif.o_Blu} === 9'b101101101) good++;
            end else if ({vif.o_Red, vif.o_Grn, vif.o_Blu} !== '0) bad++;
            step(1);
        end
        rgb_mode = 0;
        chk_cnt++;
        if (vcnt != 240) $display("FAIL frame_vs_count got %0d expected 240", vcnt);
        else pass_cnt++;
        chk_cnt++;
        if (vfirst != 23 || vlast != 25)
            $display("FAIL frame_vs_rows got %0d..%0d expected 23..25", vfirst, vlast);
        else pass_cnt++;
        chk_cnt++;
        if (good != AC * AR) $display("FAIL frame_rgb_active got %0d expected %0d", good, AC * AR);
        else pass_cnt++;
        chk_cnt++;
        if (bad != 0) $display("FAIL frame_rgb_blank got %0d nonzero expected 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (!(vif.o_Row == 10'd12 && vif.o_Col == 10'd30) && n < TC * TR + 10) begin
            step(1);
            n++;
        end
        chk_cnt++;
        if (!(vif.o_Row == 10'd12 && vif.o_Col == 10'd30))
            $display("FAIL rstmid_timeout row 12 not reached within %0d cycles", n);
        else pass_cnt++;
        #2 RST = 1'b1;
        #1;
        chk_cnt++;
        if ({vif.o_Locked, vif.o_HSync, vif.o_VSync, vif.o_Active} !== 4'b0110)
            $display("FAIL rstmid_idle got lk/hs/vs/act=%b%b%b%b expected 0110",
                     vif.o_Locked, vif.o_HSync, vif.o_VSync, vif.o_Active);
        else pass_cnt++;
        chk_cnt++;
        if ({vif.o_Red, vif.o_Grn, vif.o_Blu, vif.o_Col, vif.o_Row} !== '0)
            $display("FAIL rstmid_data got rgb=%h%h%h col=%0d row=%0d expected zeros",
                     vif.o_Red, vif.o_Grn, vif.o_Blu, vif.o_Col, vif.o_Row);
        else pass_cnt++;
        sb_q.delete();
        model_locked = 1'b0;
        repeat (4) step(0);
        release_reset();
        relock("rstmid");
        test_line("rstmid_line");
        repeat (2 * TC) step(1);
    endtask

    initial begin
        test_reset();
        test_mid_start();
        test_line("line");
        test_frame();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
